// File: rtl/watch_mode_ctrl.sv
// Watch front-panel controller: debounces three buttons, sequences the five display
// modes, routes adjust/set pulses to the active mode and drives the buzzer and timer LED.
module watch_mode_ctrl (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        mode,
    input  logic        mode1,
    input  logic        set,
    input  logic        tick,
    input  logic        alarm_hit,
    input  logic        timer_done,
    input  logic [15:0] d_clk,
    input  logic [15:0] d_set,
    input  logic [15:0] d_sw,
    input  logic [15:0] d_alm,
    input  logic [15:0] d_tmr,
    output logic [2:0]  sel,
    output logic [4:0]  mode1_out,
    output logic [4:0]  set_out,
    output logic        commit,
    output logic [15:0] digits,
    output logic        buzzer,
    output logic        led1
);

    typedef enum logic [2:0] {
        ST_CLK = 3'd0,
        ST_SET = 3'd1,
        ST_SW  = 3'd2,
        ST_ALM = 3'd3,
        ST_TMR = 3'd4
    } state_t;

    localparam logic [5:0] IDLE_LIMIT = 6'd30;
    localparam logic [5:0] RING_LIMIT = 6'd60;

    logic [2:0] btn_raw;
    logic [2:0] sync1_q, sync2_q, sync3_q, pulse_q;
    logic [2:0] valid_q;

    assign btn_raw = {set, mode1, mode};

    // valid_q[2] marks that sync3_q holds a level sampled after reset, so a button
    // held through reset release cannot masquerade as a fresh rising edge.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
            pulse_q <= '0;
            valid_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            pulse_q <= sync2_q & ~sync3_q & {3{valid_q[2]}};
            valid_q <= {valid_q[1:0], 1'b1};
        end
    end

    logic mode_p, mode1_p, set_p, any_p;
    assign mode_p  = pulse_q[0];
    assign mode1_p = pulse_q[1];
    assign set_p   = pulse_q[2];
    assign any_p   = |pulse_q;

    state_t      state_q, state_d;
    logic [5:0]  idle_q, idle_d;
    logic [5:0]  ring_q, ring_d;
    logic        buzzer_q, buzzer_d;
    logic        led_q, led_d;
    logic [4:0]  mode1_out_q, mode1_out_d;
    logic [4:0]  set_out_q, set_out_d;
    logic        commit_q, commit_d;
    logic [15:0] digits_q, digits_d;

    logic        adj_ok, set_ok, buz_clr, led_clr, timed, fwd_ok, timeout;
    logic [4:0]  onehot;

    always_comb begin
        state_d     = state_q;
        idle_d      = idle_q;
        ring_d      = ring_q;
        buzzer_d    = buzzer_q;
        led_d       = led_q;
        mode1_out_d = '0;
        set_out_d   = '0;
        commit_d    = 1'b0;
        digits_d    = d_clk;

        // A mode press swallows any adjust/set pulse arriving in the same cycle.
        adj_ok  = mode1_p & ~mode_p;
        set_ok  = set_p & ~mode_p;
        buz_clr = set_ok && (state_q == ST_ALM) && buzzer_q;
        led_clr = set_ok && (state_q == ST_TMR) && led_q;
        timed   = (state_q == ST_SET) || (state_q == ST_ALM) || (state_q == ST_TMR);
        fwd_ok  = (state_q == ST_SET) || (state_q == ST_SW) ||
                  (state_q == ST_ALM) || (state_q == ST_TMR);
        timeout = tick && !any_p && (idle_q == IDLE_LIMIT - 6'd1);
        onehot  = 5'b00001 << state_q;

        case (state_q)
            ST_CLK: if (mode_p) state_d = ST_SET;
            ST_SET: begin
                if (mode_p) begin
                    state_d  = ST_SW;
                    commit_d = 1'b1;
                end else if (timeout) begin
                    state_d = ST_CLK;
                end
            end
            ST_SW:  if (mode_p) state_d = ST_ALM;
            ST_ALM: begin
                if (mode_p)       state_d = ST_TMR;
                else if (timeout) state_d = ST_CLK;
            end
            ST_TMR: begin
                if (mode_p || timeout) state_d = ST_CLK;
            end
            default: state_d = ST_CLK;
        endcase

        if (any_p || (state_d != state_q) || !timed) idle_d = '0;
        else if (tick)                               idle_d = idle_q + 6'd1;

        if (fwd_ok && adj_ok)                         mode1_out_d = onehot;
        if (fwd_ok && set_ok && !buz_clr && !led_clr) set_out_d   = onehot;

        if (alarm_hit) begin
            buzzer_d = 1'b1;
            ring_d   = '0;
        end else if (buz_clr) begin
            buzzer_d = 1'b0;
            ring_d   = '0;
        end else if (buzzer_q && tick) begin
            if (ring_q == RING_LIMIT - 6'd1) begin
                buzzer_d = 1'b0;
                ring_d   = '0;
            end else begin
                ring_d = ring_q + 6'd1;
            end
        end

        if (timer_done)   led_d = 1'b1;
        else if (led_clr) led_d = 1'b0;

        case (state_q)
            ST_SET:  digits_d = d_set;
            ST_SW:   digits_d = d_sw;
            ST_ALM:  digits_d = d_alm;
            ST_TMR:  digits_d = d_tmr;
            default: digits_d = d_clk;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q     <= ST_CLK;
            idle_q      <= '0;
            ring_q      <= '0;
            buzzer_q    <= 1'b0;
            led_q       <= 1'b0;
            mode1_out_q <= '0;
            set_out_q   <= '0;
            commit_q    <= 1'b0;
            digits_q    <= '0;
        end else begin
            state_q     <= state_d;
            idle_q      <= idle_d;
            ring_q      <= ring_d;
            buzzer_q    <= buzzer_d;
            led_q       <= led_d;
            mode1_out_q <= mode1_out_d;
            set_out_q   <= set_out_d;
            commit_q    <= commit_d;
            digits_q    <= digits_d;
        end
    end

    assign sel       = state_q;
    assign mode1_out = mode1_out_q;
    assign set_out   = set_out_q;
    assign commit    = commit_q;
    assign digits    = digits_q;
    assign buzzer    = buzzer_q;
    assign led1      = led_q;

endmodule

// File: doc/watch_mode_ctrl.md
WATCH_MODE_CTRL -- requirements
Module: watch_mode_ctrl

Interface
REQ-001 clk_in  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 mode  input  1  mode button, raw asynchronous level.
REQ-004 mode1  input  1  adjust button, raw asynchronous level.
REQ-005 set  input  1  set/start button, raw asynchronous level.
REQ-006 tick  input  1  one-cycle 1 Hz strobe, synchronous to clk_in.
REQ-007 alarm_hit  input  1  one-cycle alarm-match strobe from alarm block.
REQ-008 timer_done  input  1  one-cycle expiry strobe from timer block.
REQ-009 d_clk, d_set, d_sw, d_alm, d_tmr  input  16 each  four BCD digits {h1,h0,m1,m0} from clock, set, stopwatch, alarm, timer blocks.
REQ-010 sel  output  3  active mode: 0 clock, 1 set, 2 stopwatch, 3 alarm, 4 timer.
REQ-011 mode1_out  output  5  one-hot adjust pulse; bit i targets mode i.
REQ-012 set_out  output  5  one-hot set pulse; bit i targets mode i.
REQ-013 commit  output  1  one-cycle pulse loading set-block time into clock block.
REQ-014 digits  output  16  registered display digits of active mode.
REQ-015 buzzer  output  1  alarm annunciator.
REQ-016 led1  output  1  timer-expired indicator.

Function
REQ-017 Each button SHALL pass a 2-flop synchronizer then a rising-edge detector producing a one-cycle pulse (mode_p, mode1_p, set_p); latency from input edge to pulse 3 cycles.
REQ-018 State machine SHALL have states CLK(0), SET(1), SW(2), ALM(3), TMR(4); mode_p advances 0->1->2->3->4->0; no other transition except REQ-022.
REQ-019 sel SHALL equal current state encoding; values 5-7 unreachable, and if ever present SHALL return to CLK next cycle.
REQ-020 mode1_p/set_p SHALL be forwarded the next cycle on bit sel of mode1_out/set_out; all other bits 0; in CLK state both outputs stay 0.
REQ-021 commit SHALL pulse one cycle when mode_p occurs while in SET, coincident with the SET->SW transition.
REQ-022 Inactivity timeout: 6-bit counter cleared on any button pulse or state change, incremented on tick in states SET, ALM, TMR; at count 30 state SHALL return to CLK without commit; SW never times out.
REQ-023 Simultaneous mode_p with mode1_p or set_p in same cycle: mode_p wins, other pulses dropped (not forwarded to either state).
REQ-024 digits SHALL register the selected 16-bit source each cycle (1-cycle latency after sel change).
REQ-025 buzzer SHALL set on alarm_hit in any state; clear on set_p while in ALM (that set_p is consumed, not forwarded) or after 60 ticks of ringing; alarm_hit while ringing restarts the 60-tick count.
REQ-026 led1 SHALL set on timer_done in any state; clear on set_p while in TMR (consumed, not forwarded).
REQ-027 Set and clear in same cycle for buzzer or led1: set wins.

Reset
REQ-028 On rst high, immediately: state CLK, sel 0, mode1_out 0, set_out 0, commit 0, digits 0, buzzer 0, led1 0, all counters and synchronizers 0.
REQ-029 Reset mid-operation SHALL abandon any pending pulse; a button held high through reset release SHALL NOT produce a pulse until released and pressed again.

Verification
REQ-030 Five mode presses from reset -> sel 1,2,3,4,0 in order; commit pulses once exactly at the 1->2 step.
REQ-031 In SW, press set -> set_out = 5'b00100 for exactly one cycle; mode1_out stays 0.
REQ-032 Enter SET, apply 30 ticks with no buttons -> sel returns 0 on 30th tick, commit never asserted; repeat in SW -> sel stays 2.
REQ-033 alarm_hit in CLK -> buzzer 1; 60 ticks later buzzer 0; second run, enter ALM and press set -> buzzer 0, set_out stays 0.
REQ-034 mode and set edges synchronized into same cycle in SW -> sel becomes 3, set_out all 0.
REQ-035 Assert rst while in TMR with led1 1 and set held high -> all outputs 0 at once; after release no set_out pulse until set falls and rises.
